md_checker: RTL and testbench

Stream receiver and pattern checker for the metadata test path. It consumes the AXI-Stream that the metadata generator produces: every beat carries one byte replicated across all DW/8 lanes, the first beat after start is 0x01, and the byte increments by 1 (mod 256) on every accepted beat. The block sits at the far end of the stream, after the DUT path, and reports beat count, error count and first-error capture to the test harness.

---
 rtl/md_checker.sv | 180 ++++++++++++++++++
 tb/tb_md_checker.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/md_checker.sv
// Receiver/checker for the replicated-byte incrementing metadata stream.
// Optional MD_CHECKER_THROTTLE_EN drops axis_tready one cycle in four while running.
module md_checker #(
   parameter int DW = 512
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic          stop,
   input  logic [DW-1:0] axis_tdata,
   input  logic          axis_tvalid,
   output logic          axis_tready,
   output logic          running,
   output logic [31:0]   beat_count,
   output logic [31:0]   error_count,
   output logic          error,
   output logic [31:0]   first_err_beat,
   output logic [7:0]    first_err_expected,
   output logic [7:0]    first_err_lane0
);

   localparam int LANES = DW / 8;

   typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

   state_t      state_reg, state_next;

   logic [7:0]  expected_reg, expected_next;
   logic [31:0] beat_count_reg, beat_count_next;
   logic [31:0] error_count_reg, error_count_next;
   logic        error_reg, error_next;
   logic [31:0] first_err_beat_reg, first_err_beat_next;
   logic [7:0]  first_err_expected_reg, first_err_expected_next;
   logic [7:0]  first_err_lane0_reg, first_err_lane0_next;

   logic        clear_stat;
   logic        accept;
   logic        mismatch;
   logic [LANES-1:0] lane_mismatch;

   // Each lane is compared independently; any differing lane flags the beat.
   genvar gi;
   generate
      for (gi = 0; gi < LANES; gi++) begin : g_lane
         assign lane_mismatch[gi] = (axis_tdata[gi*8 +: 8] != expected_reg);
      end
   endgenerate

   assign mismatch = |lane_mismatch;

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg <= ST_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE: if (start) state_next = ST_RUN;
         ST_RUN: begin
            if (start)     state_next = ST_RUN;
            else if (stop) state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // ---------------- FSM: control outputs ----------------
   // A start in the same cycle as a handshake discards that beat.
   always_comb begin
      clear_stat = 1'b0;
      accept     = 1'b0;
      case (state_reg)
         ST_IDLE: clear_stat = start;
         ST_RUN: begin
            clear_stat = start;
            accept     = axis_tvalid & axis_tready & ~start;
         end
         default: begin
            clear_stat = 1'b0;
            accept     = 1'b0;
         end
      endcase
   end

   assign running = (state_reg == ST_RUN);

`ifdef MD_CHECKER_THROTTLE_EN
   logic [1:0] thr_reg, thr_next;
   logic       tready_reg, tready_next;

   always_comb begin
      thr_next = thr_reg;
      if (start)                   thr_next = 2'd0;
      else if (state_reg == ST_RUN) thr_next = thr_reg + 2'd1;
      tready_next = (state_next == ST_RUN) && (thr_next != 2'd3);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         thr_reg    <= 2'd0;
         tready_reg <= 1'b0;
      end else begin
         thr_reg    <= thr_next;
         tready_reg <= tready_next;
      end
   end

   assign axis_tready = tready_reg;
`else
   assign axis_tready = running;
`endif

   // ---------------- status datapath ----------------
   always_comb begin
      expected_next           = expected_reg;
      beat_count_next         = beat_count_reg;
      error_count_next        = error_count_reg;
      error_next              = error_reg;
      first_err_beat_next     = first_err_beat_reg;
      first_err_expected_next = first_err_expected_reg;
      first_err_lane0_next    = first_err_lane0_reg;
      if (clear_stat) begin
         expected_next           = 8'h01;
         beat_count_next         = 32'd0;
         error_count_next        = 32'd0;
         error_next              = 1'b0;
         first_err_beat_next     = 32'd0;
         first_err_expected_next = 8'h00;
         first_err_lane0_next    = 8'h00;
      end else if (accept) begin
         // The expected sequence advances on every beat; no resync after an error.
         beat_count_next = beat_count_reg + 32'd1;
         expected_next   = expected_reg + 8'h01;
         if (mismatch) begin
            if (error_count_reg != 32'hFFFF_FFFF)
               error_count_next = error_count_reg + 32'd1;
            if (!error_reg) begin
               error_next              = 1'b1;
               first_err_beat_next     = beat_count_reg;
               first_err_expected_next = expected_reg;
               first_err_lane0_next    = axis_tdata[7:0];
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         expected_reg           <= 8'h01;
         beat_count_reg         <= 32'd0;
         error_count_reg        <= 32'd0;
         error_reg              <= 1'b0;
         first_err_beat_reg     <= 32'd0;
         first_err_expected_reg <= 8'h00;
         first_err_lane0_reg    <= 8'h00;
      end else begin
         expected_reg           <= expected_next;
         beat_count_reg         <= beat_count_next;
         error_count_reg        <= error_count_next;
         error_reg              <= error_next;
         first_err_beat_reg     <= first_err_beat_next;
         first_err_expected_reg <= first_err_expected_next;
         first_err_lane0_reg    <= first_err_lane0_next;
      end
   end

   assign beat_count         = beat_count_reg;
   assign error_count        = error_count_reg;
   assign error              = error_reg;
   assign first_err_beat     = first_err_beat_reg;
   assign first_err_expected = first_err_expected_reg;
   assign first_err_lane0    = first_err_lane0_reg;

endmodule

// File: tb/tb_md_checker.sv
// Directed bench for md_checker: clean run, lane error, saturation, start/stop corners, reset.
// Build with MD_CHECKER_THROTTLE_EN defined to cover the throttled-ready variant.
module tb_md_checker;

   localparam int DW    = 64;
   localparam int LANES = DW / 8;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          start = 1'b0;
   logic          stop = 1'b0;
   logic [DW-1:0] axis_tdata = '0;
   logic          axis_tvalid = 1'b0;
   logic          axis_tready;
   logic          running;
   logic [31:0]   beat_count;
   logic [31:0]   error_count;
   logic          error;
   logic [31:0]   first_err_beat;
   logic [7:0]    first_err_expected;
   logic [7:0]    first_err_lane0;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   md_checker #(.DW(DW)) dut (
      .clk                (clk),
      .reset              (reset),
      .start              (start),
      .stop               (stop),
      .axis_tdata         (axis_tdata),
      .axis_tvalid        (axis_tvalid),
      .axis_tready        (axis_tready),
      .running            (running),
      .beat_count         (beat_count),
      .error_count        (error_count),
      .error              (error),
      .first_err_beat     (first_err_beat),
      .first_err_expected (first_err_expected),
      .first_err_lane0    (first_err_lane0)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [DW-1:0] rep(input logic [7:0] b);
      return {LANES{b}};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic timeout_fail(input string tag);
      n_checks++;
      n_fail++;
      $error("FAIL %s: observed no handshake expected handshake within 16 cycles", tag);
   endtask

   // Holds the beat until it is handshaken; leaves tvalid high for back-to-back use.
   task automatic send_beat(input logic [DW-1:0] d);
      logic hs;
      axis_tdata  = d;
      axis_tvalid = 1'b1;
      for (int k = 0; k < 16; k++) begin
         hs = axis_tready;
         tick();
         if (hs) return;
      end
      timeout_fail("send_beat");
   endtask

   task automatic wait_ready();
      for (int k = 0; k < 16; k++) begin
         if (axis_tready) return;
         tick();
      end
      timeout_fail("wait_ready");
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic check_all_zero(input string pfx);
      check({pfx, "_tready"},  32'(axis_tready), 32'd0);
      check({pfx, "_running"}, 32'(running), 32'd0);
      check({pfx, "_beats"},   beat_count, 32'd0);
      check({pfx, "_errcnt"},  error_count, 32'd0);
      check({pfx, "_error"},   32'(error), 32'd0);
      check({pfx, "_febeat"},  first_err_beat, 32'd0);
      check({pfx, "_feexp"},   32'(first_err_expected), 32'd0);
      check({pfx, "_felane0"}, 32'(first_err_lane0), 32'd0);
   endtask

   initial begin
      int c0;
      int low;
      logic [DW-1:0] bad;

      // Reset state
      tick();
      tick();
      check_all_zero("reset");
      reset = 1'b0;
      tick();

      // Clean run, 300 beats wrapping through 0xFF, 0x00
      pulse_start();
      check("start_running", 32'(running), 32'd1);
      check("start_tready", 32'(axis_tready), 32'd1);
      c0 = cyc;
      for (int i = 0; i < 300; i++) send_beat(rep(8'((i + 1) % 256)));
      axis_tvalid = 1'b0;
`ifndef MD_CHECKER_THROTTLE_EN
      check("clean_cycles", 32'(cyc - c0), 32'd300);
`endif
      check("clean_beats", beat_count, 32'd300);
      check("clean_errcnt", error_count, 32'd0);
      check("clean_error", 32'(error), 32'd0);
      $display("clean run: beats=%0d errors=%0d", beat_count, error_count);

      // Single top-lane error on beat 5
      pulse_start();
      check("restart_beats", beat_count, 32'd0);
      for (int i = 0; i < 10; i++) begin
         if (i == 5) begin
            bad = rep(8'h06);
            bad[DW-1 -: 8] = 8'h07;
            send_beat(bad);
         end else begin
            send_beat(rep(8'(i + 1)));
         end
      end
      axis_tvalid = 1'b0;
      check("lane_error", 32'(error), 32'd1);
      check("lane_errcnt", error_count, 32'd1);
      check("lane_febeat", first_err_beat, 32'd5);
      check("lane_feexp", 32'(first_err_expected), 32'h06);
      check("lane_felane0", 32'(first_err_lane0), 32'h06);
      check("lane_beats", beat_count, 32'd10);
      $display("lane error: errcnt=%0d first_beat=%0d", error_count, first_err_beat);

      // Saturation: preload near the top, then three bad beats
      force dut.error_count_reg = 32'hFFFF_FFFE;
      tick();
      release dut.error_count_reg;
      for (int i = 0; i < 3; i++) send_beat(rep(8'hAA));
      axis_tvalid = 1'b0;
      check("sat_errcnt", error_count, 32'hFFFF_FFFF);
      check("sat_febeat", first_err_beat, 32'd5);
      check("sat_feexp", 32'(first_err_expected), 32'h06);
      check("sat_felane0", 32'(first_err_lane0), 32'h06);
      check("sat_beats", beat_count, 32'd13);
      $display("saturation: errcnt=0x%08h", error_count);

      // Handshake coincident with stop is still counted and checked
      wait_ready();
      axis_tdata  = rep(8'h0E);
      axis_tvalid = 1'b1;
      stop = 1'b1;
      tick();
      stop = 1'b0;
      check("stop_beats", beat_count, 32'd14);
      check("stop_errcnt", error_count, 32'hFFFF_FFFF);
      check("stop_running", 32'(running), 32'd0);
      check("stop_tready", 32'(axis_tready), 32'd0);
      tick();
      axis_tvalid = 1'b0;
      check("idle_hold_beats", beat_count, 32'd14);
      check("idle_hold_error", 32'(error), 32'd1);
      $display("stop: beats=%0d running=%0d", beat_count, running);

      // start and stop together: start wins
      start = 1'b1;
      stop  = 1'b1;
      tick();
      start = 1'b0;
      stop  = 1'b0;
      check("ss_running", 32'(running), 32'd1);
      check("ss_beats", beat_count, 32'd0);
      check("ss_errcnt", error_count, 32'd0);
      check("ss_error", 32'(error), 32'd0);
      check("ss_febeat", first_err_beat, 32'd0);
      $display("start+stop: running=%0d beats=%0d", running, beat_count);

      // start in RUN with a concurrent handshake: beat dropped, sequence restarts at 0x01
      for (int i = 0; i < 3; i++) send_beat(rep(8'(i + 1)));
      axis_tvalid = 1'b0;
      wait_ready();
      axis_tdata  = rep(8'h04);
      axis_tvalid = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      axis_tvalid = 1'b0;
      check("rst_run_beats", beat_count, 32'd0);
      send_beat(rep(8'h01));
      axis_tvalid = 1'b0;
      check("rst_run_next_beats", beat_count, 32'd1);
      check("rst_run_next_error", 32'(error), 32'd0);
      $display("start in run: beats=%0d error=%0d", beat_count, error);

      // Random tvalid gaps give the same result as the clean run
      pulse_start();
      for (int i = 0; i < 300; i++) begin
         axis_tvalid = 1'b0;
         repeat ($urandom_range(0, 2)) tick();
         send_beat(rep(8'((i + 1) % 256)));
      end
      axis_tvalid = 1'b0;
      check("bp_beats", beat_count, 32'd300);
      check("bp_errcnt", error_count, 32'd0);
      check("bp_error", 32'(error), 32'd0);
      $display("backpressure: beats=%0d errors=%0d", beat_count, error_count);

      // Reset mid-stream with a beat in flight
      pulse_start();
      for (int i = 0; i < 5; i++) send_beat(rep(8'h55));
      wait_ready();
      reset = 1'b1;
      tick();
      check_all_zero("midreset");
      reset = 1'b0;
      axis_tvalid = 1'b0;
      tick();
      $display("mid-stream reset: beats=%0d running=%0d", beat_count, running);

      // Ready duty over 12 cycles in RUN
      pulse_start();
      low = 0;
      for (int i = 0; i < 12; i++) begin
         if (!axis_tready) low++;
         tick();
      end
`ifdef MD_CHECKER_THROTTLE_EN
      check("throttle_low", 32'(low), 32'd3);
`else
      check("throttle_low", 32'(low), 32'd0);
`endif
      $display("ready low cycles in 12: %0d", low);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
